// File: rtl/mvm_result_serializer.sv
// Result serializer for the matrix-vector multiplier: waits out the pipeline
// latency in enabled cycles, snapshots the row results and streams them as bytes.

module mvm_row_sext #(
  parameter int W_Y   = 19,
  parameter int BYTES = 3
) (
  input  logic [W_Y-1:0]        y,
  output logic [BYTES-1:0][7:0] b
);
  localparam int PAD = BYTES*8 - W_Y;

  generate
    if (PAD > 0) begin : g_pad
      assign b = {{PAD{y[W_Y-1]}}, y};
    end else begin : g_nopad
      assign b = y;
    end
  endgenerate
endmodule

module mvm_result_serializer #(
  parameter int R       = 8,
  parameter int W_Y     = 19,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             start,
  input  logic [R*W_Y-1:0] yf,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             drop
);
  localparam int BYTES = (W_Y + 7) / 8;
  localparam int NB    = R * BYTES;
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [7:0]              data_n;
  logic                    valid_n, busy_n, drop_n, cap;
  logic [R-1:0][BYTES-1:0][7:0] sext;
  logic [NB-1:0][7:0]      sext_b, bytes_q;

  // Row r lands at byte indices r*BYTES.., LSB first, by packed layout.
  genvar r;
  generate
    for (r = 0; r < R; r++) begin : g_row
      mvm_row_sext #(.W_Y(W_Y), .BYTES(BYTES)) u_sext (
        .y(yf[r*W_Y +: W_Y]),
        .b(sext[r])
      );
    end
  endgenerate

  assign sext_b = sext;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = m_data;
    valid_n = m_valid;
    cap     = 1'b0;
    drop_n  = start & cen & (state != IDLE);
    case (state)
      IDLE: if (start & cen) begin
        cnt_n   = CW'(1);
        state_n = WAIT;
      end
      WAIT: if (cnt == CW'(LATENCY)) begin
        // yf is valid now; capture regardless of cen at this edge
        cap     = 1'b1;
        state_n = SEND;
        idx_n   = '0;
        valid_n = 1'b1;
        data_n  = sext_b[0];
      end else if (cen) begin
        cnt_n = cnt + CW'(1);
      end
      SEND: if (m_ready) begin
        if (idx == IW'(NB-1)) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
          valid_n = 1'b0;
          data_n  = 8'h00;
        end else begin
          idx_n  = idx + IW'(1);
          data_n = bytes_q[idx_n];
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      m_data  <= data_n;
      m_valid <= valid_n;
      busy    <= busy_n;
      drop    <= drop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) bytes_q <= sext_b;
  end
endmodule

// File: tb/tb_mvm_result_serializer.sv
// Scoreboard bench for mvm_result_serializer: default build plus a one-byte build.
module tb_mvm_result_serializer;
  localparam int R = 8, W_Y = 19, LAT = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic cen = 1'b1, start = 1'b0, m_ready = 1'b1;
  logic [R*W_Y-1:0] yf;
  logic [7:0] m_data;
  logic m_valid, busy, drop;

  logic start2 = 1'b0;
  logic [7:0] yf2 = 8'h80;
  logic [7:0] m_data2;
  logic m_valid2, busy2, drop2;

  int n_chk = 0, n_pass = 0;
  int hs = 0, drops = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held;
  bit hold_chk = 0, bp_en = 0;
  int ph = 0;

  localparam logic [R*W_Y-1:0] ROWS = {19'h4, 19'h3, 19'h2, 19'h1,
                                       19'h40000, 19'h3FFFF, 19'h7FFFF, 19'h00123};

  mvm_result_serializer #(.R(R), .W_Y(W_Y), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .yf(yf),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .drop(drop)
  );

  mvm_result_serializer #(.R(1), .W_Y(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .cen(1'b1), .start(start2), .yf(yf2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(1'b1),
    .busy(busy2), .drop(drop2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Backpressure pattern 1,0,0 repeating when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      m_ready = (ph == 0);
      ph = (ph + 1) % 3;
    end else begin
      m_ready = 1'b1;
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (drop) drops++;
      if (hold_chk) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held);
        hold_chk = 0;
      end
      if (m_valid) begin
        if (m_ready) begin
          if (exp_q.size() == 0) chk("extra_byte", m_data, 32'hFFFF_FFFF);
          else chk("byte", m_data, exp_q.pop_front());
          hs++;
        end else begin
          held = m_data;
          hold_chk = 1;
        end
      end
    end
  end

  task automatic push_expected();
    logic [W_Y-1:0] v;
    logic [23:0] e;
    for (int i = 0; i < R; i++) begin
      v = yf[i*W_Y +: W_Y];
      e = {{5{v[W_Y-1]}}, v};
      exp_q.push_back(e[7:0]);
      exp_q.push_back(e[15:8]);
      exp_q.push_back(e[23:16]);
    end
  endtask

  task automatic run_stream(input int stall, input bit ovr, input bit zero_after);
    int n, t, h0, d0;
    logic [R*W_Y-1:0] saved;
    h0 = hs; d0 = drops; saved = yf;
    push_expected();
    start = 1; cen = 1;
    @(posedge clk); #1;
    start = 0;
    n = 1;
    while (!m_valid && n < 40) begin
      cen = (n <= stall) ? 1'b0 : 1'b1;
      start = (ovr && n == 2);
      @(posedge clk); #1;
      n++;
    end
    start = 0; cen = 1;
    chk("first_valid_edge", n, LAT + 1 + stall);
    chk("busy_in_send", busy, 1);
    if (zero_after) yf = '0;
    if (ovr) begin
      repeat (3) begin @(posedge clk); #1; end
      start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", exp_q.size(), 0);
    chk("valid_end", m_valid, 0);
    chk("busy_end", busy, 0);
    chk("handshakes", hs - h0, 24);
    chk("drops", drops - d0, ovr ? 2 : 0);
    yf = saved;
  endtask

  initial begin
    int t, h0, d0, n;
    yf = ROWS;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    rst = 0;
    @(posedge clk); #1;

    run_stream(0, 0, 0);

    // start without cen in IDLE is silently ignored
    d0 = drops;
    start = 1; cen = 0;
    repeat (2) begin @(posedge clk); #1; end
    start = 0; cen = 1;
    @(posedge clk); #1;
    chk("nocen_busy", busy, 0);
    chk("nocen_valid", m_valid, 0);
    chk("nocen_drop", drops - d0, 0);

    run_stream(3, 0, 0);

    bp_en = 1;
    run_stream(0, 0, 1);
    bp_en = 0;
    @(posedge clk); #1;

    run_stream(0, 1, 0);
    run_stream(0, 0, 0);

    // asynchronous reset mid-stream
    h0 = hs;
    push_expected();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    t = 0;
    while (hs - h0 < 10 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("pre_rst_bytes", hs - h0, 10);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    run_stream(0, 0, 0);

    // LATENCY=1, one 8-bit row
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    n = 1;
    while (!m_valid2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("l1_first_valid_edge", n, 2);
    chk("l1_data", m_data2, 8'h80);
    chk("l1_busy", busy2, 1);
    @(posedge clk); #1;
    chk("l1_valid_end", m_valid2, 0);
    chk("l1_busy_end", busy2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
